led_matrix_bcm_driver: RTL and testbench
========================================

LED_MATRIX_BCM_DRIVER -- requirements
Module: led_matrix_bcm_driver

Interface
REQ-001 SHALL have parameter COLS, default 32: columns per row, the number of shift clocks per row.
REQ-002 SHALL have parameter ROW_PAIRS, default 8: multiplexed row pairs; ABC_W = $clog2(ROW_PAIRS).
REQ-003 SHALL have parameter DEPTH, default 4: bits per colour channel, which is also the number of bit-planes.
REQ-004 SHALL have parameter CLK_DIV, default 2 (minimum 2): clk cycles per sclk half-period.
REQ-005 SHALL have parameter BASE_T, default 16: display cycles for bit-plane 0.
REQ-006 SHALL have ports clk (in, 1, system clock) and rst (in, 1); one clock, reset synchronous and active-high.
REQ-007 SHALL have port en (in, 1): run/stop request.
REQ-008 SHALL have port pix_addr (out, ABC_W+$clog2(COLS)): framebuffer read address {row, col}.
REQ-009 SHALL have ports pix_top and pix_bot (in, 3*DEPTH each): {R,G,B} pixel data, one-cycle read latency.
REQ-010 SHALL have ports sclk, lat, blank (out, 1 each): panel shift clock, latch, and output-disable.
REQ-011 SHALL have ports r1, g1, b1, r2, g2, b2 (out, 1 each): serial colour data for the top and bottom half.
REQ-012 SHALL have port abc (out, ABC_W): row-pair address.
REQ-013 SHALL have port frame_done (out, 1): one-cycle pulse at frame end.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT, LATCH, DISPLAY.
REQ-015 IDLE SHALL move to SHIFT when en=1, with row=0, plane=0, col=0.
REQ-016 SHIFT, per column, SHALL drive sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles; a row takes 2*CLK_DIV*COLS cycles.
REQ-017 pix_addr SHALL be presented in the first cycle of each low phase; colour outputs SHALL be registered in the second cycle.
REQ-018 Colour outputs SHALL hold stable through the high phase.
REQ-019 Colour mapping: r1 = pix_top[2*DEPTH+plane], g1 = pix_top[DEPTH+plane], b1 = pix_top[plane]; r2, g2, b2 likewise from pix_bot.
REQ-020 After the last column's high phase, the FSM SHALL enter LATCH for exactly 1 cycle with lat=1, sclk=0, blank=1.
REQ-021 abc SHALL update to the current row in the LATCH cycle, and only then.
REQ-022 DISPLAY SHALL hold blank=0 for exactly BASE_T<<plane cycles, with lat=0 and sclk=0.
REQ-023 blank SHALL be 1 in every state other than DISPLAY.
REQ-024 At DISPLAY end: if plane<DEPTH-1, plane SHALL increment; otherwise plane SHALL clear to 0 and row SHALL increment.
REQ-025 Row SHALL wrap from ROW_PAIRS-1 to 0, with frame_done=1 for the single cycle of that wrap.
REQ-026 If en=0 at DISPLAY end, the FSM SHALL go to IDLE and counters SHALL reset to 0; en is not sampled mid-SHIFT or mid-DISPLAY.
REQ-027 If en=1 at DISPLAY end, the next SHIFT SHALL begin on the following cycle, with no idle gap.
REQ-028 Frame length SHALL be ROW_PAIRS*(DEPTH*(2*CLK_DIV*COLS+1) + BASE_T*(2^DEPTH-1)) cycles.
REQ-029 Counter widths SHALL be $clog2-derived from the parameters; the display counter SHALL be wide enough for BASE_T<<(DEPTH-1).

Reset
REQ-030 rst=1 SHALL force IDLE and clear all counters.
REQ-031 Reset output values: sclk=0, lat=0, blank=1, colour outputs 0, abc=0, pix_addr=0, frame_done=0.
REQ-032 Reset asserted in any state, mid-operation, SHALL take effect at the next clk edge; no partial latch pulse may follow.

Structure
REQ-033 Package led_pkg SHALL hold the FSM state typedef (state_t) and default parameter constants.
REQ-034 One sub-module, bcm_timer, SHALL implement the DISPLAY down-counter: load BASE_T<<plane, assert done on reaching 0.
REQ-035 All outputs SHALL be registered.

Verification (COLS=4, ROW_PAIRS=2, DEPTH=2, CLK_DIV=2, BASE_T=8 unless noted)
REQ-036 Reset with en=1 -> blank=1, sclk=0, lat=0 throughout reset; first sclk rise 2 cycles after the reset release edge plus the IDLE cycle.
REQ-037 Framebuffer model: pix_top = 6'b10_01_11 everywhere -> plane 0: r1=0, g1=1, b1=1; plane 1: r1=1, g1=0, b1=1; exactly 4 sclk rises per plane.
REQ-038 Steady run -> DISPLAY blank-low widths 8 then 16 cycles per row; lat pulses exactly 1 cycle wide; abc changes only on lat cycles.
REQ-039 Frame boundary -> frame_done pulses once every 2*(2*(16+1)+24) = 116 cycles; abc sequence 0,0,1,1,0.
REQ-040 en deasserted mid-SHIFT -> current plane completes through DISPLAY, then IDLE with blank=1; re-assert en -> restarts at row 0, plane 0.
REQ-041 rst pulsed during DISPLAY of row 1 -> next cycle: blank=1, abc=0; restart at row 0 when rst falls.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared FSM state type and default parameters for the LED matrix BCM driver
package led_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH,
      DISPLAY
   } state_t;

   localparam int DEF_COLS      = 32;
   localparam int DEF_ROW_PAIRS = 8;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_BASE_T    = 16;

endpackage

// File: rtl/bcm_timer.sv
// rtl/bcm_timer.sv - binary-code-modulation display down-counter, loads BASE_T<<plane
module bcm_timer #(
   parameter int BASE_T = 16,
   parameter int PW     = 2,
   parameter int TW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [PW-1:0] plane,
   output logic          done
);

   logic [TW-1:0] count;

   // Loading N-1 gives exactly N cycles from the load edge to the cycle where done is seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= TW'((BASE_T << plane) - 1);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/led_matrix_bcm_driver.sv
// rtl/led_matrix_bcm_driver.sv - HUB75-style LED matrix scanner with bit-plane BCM dimming
module led_matrix_bcm_driver
   import led_pkg::*;
#(
   parameter int  COLS      = DEF_COLS,
   parameter int  ROW_PAIRS = DEF_ROW_PAIRS,
   parameter int  DEPTH     = DEF_DEPTH,
   parameter int  CLK_DIV   = DEF_CLK_DIV,
   parameter int  BASE_T    = DEF_BASE_T,
   localparam int ABC_W     = $clog2(ROW_PAIRS),
   localparam int COL_W     = $clog2(COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic [ABC_W+COL_W-1:0] pix_addr,
   input  logic [3*DEPTH-1:0]     pix_top,
   input  logic [3*DEPTH-1:0]     pix_bot,
   output logic                   sclk,
   output logic                   lat,
   output logic                   blank,
   output logic                   r1,
   output logic                   g1,
   output logic                   b1,
   output logic                   r2,
   output logic                   g2,
   output logic                   b2,
   output logic [ABC_W-1:0]       abc,
   output logic                   frame_done
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam int TW = $clog2((BASE_T << (DEPTH - 1)) + 1);

   state_t           state;
   logic [ABC_W-1:0] row;
   logic [PW-1:0]    plane;
   logic [COL_W-1:0] col;
   logic [CW-1:0]    cnt;
   logic             tmr_done;
   logic             plane_last;
   logic             row_last;
   logic [ABC_W-1:0] row_nxt;

   logic [DEPTH-1:0] rt, gt, bt, rb, gb, bb;
   assign rt = pix_top[3*DEPTH-1:2*DEPTH];
   assign gt = pix_top[2*DEPTH-1:DEPTH];
   assign bt = pix_top[DEPTH-1:0];
   assign rb = pix_bot[3*DEPTH-1:2*DEPTH];
   assign gb = pix_bot[2*DEPTH-1:DEPTH];
   assign bb = pix_bot[DEPTH-1:0];

   assign plane_last = (plane == PW'(DEPTH - 1));
   assign row_last   = (row == ABC_W'(ROW_PAIRS - 1));
   assign row_nxt    = !plane_last ? row : (row_last ? '0 : row + 1'b1);

   bcm_timer #(
      .BASE_T (BASE_T),
      .PW     (PW),
      .TW     (TW)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (state == LATCH),
      .plane  (plane),
      .done   (tmr_done)
   );

   // cnt is the cycle index within the current column: low phase 0..CLK_DIV-1, high phase after.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         plane      <= '0;
         col        <= '0;
         cnt        <= '0;
         pix_addr   <= '0;
         sclk       <= 1'b0;
         lat        <= 1'b0;
         blank      <= 1'b1;
         abc        <= '0;
         frame_done <= 1'b0;
         {r1, g1, b1, r2, g2, b2} <= '0;
      end else begin
         lat        <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state    <= SHIFT;
                  row      <= '0;
                  plane    <= '0;
                  col      <= '0;
                  cnt      <= '0;
                  pix_addr <= '0;
               end
            end
            SHIFT: begin
               // Framebuffer data for the address shown at cnt==0 arrives during cnt==1.
               if (cnt == CW'(1)) begin
                  r1 <= rt[plane];
                  g1 <= gt[plane];
                  b1 <= bt[plane];
                  r2 <= rb[plane];
                  g2 <= gb[plane];
                  b2 <= bb[plane];
               end
               if (cnt == CW'(CLK_DIV - 1)) begin
                  sclk <= 1'b1;
               end
               if (cnt == CW'(2 * CLK_DIV - 1)) begin
                  sclk <= 1'b0;
                  cnt  <= '0;
                  if (col == COL_W'(COLS - 1)) begin
                     state <= LATCH;
                     lat   <= 1'b1;
                     abc   <= row;
                     col   <= '0;
                  end else begin
                     col      <= col + 1'b1;
                     pix_addr <= {row, col + 1'b1};
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LATCH: begin
               state <= DISPLAY;
               blank <= 1'b0;
            end
            DISPLAY: begin
               if (tmr_done) begin
                  blank      <= 1'b1;
                  frame_done <= plane_last && row_last;
                  if (en) begin
                     state    <= SHIFT;
                     row      <= row_nxt;
                     plane    <= plane_last ? '0 : plane + 1'b1;
                     pix_addr <= {row_nxt, COL_W'(0)};
                  end else begin
                     state <= IDLE;
                     row   <= '0;
                     plane <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_matrix_bcm_driver.sv
// tb/tb_led_matrix_bcm_driver.sv - scoreboard bench for led_matrix_bcm_driver
module tb_led_matrix_bcm_driver;

   localparam int COLS      = 4;
   localparam int ROW_PAIRS = 2;
   localparam int DEPTH     = 2;
   localparam int CLK_DIV   = 2;
   localparam int BASE_T    = 8;
   localparam int ABC_W     = 1;
   localparam int AW        = 3;
   localparam int NPIX      = ROW_PAIRS * COLS;
   localparam int FRAME_LEN = ROW_PAIRS * (DEPTH * (2 * CLK_DIV * COLS + 1) + BASE_T * ((1 << DEPTH) - 1));

   typedef struct {
      int          row;
      int          plane;
      logic [63:0] data;
      int          width;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b1;
   logic [AW-1:0]    pix_addr;
   logic [5:0]       pix_top, pix_bot;
   logic             sclk, lat, blank, r1, g1, b1, r2, g2, b2, frame_done;
   logic [ABC_W-1:0] abc;

   logic [5:0] fb_top [NPIX];
   logic [5:0] fb_bot [NPIX];
   exp_t       q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cycle = 0;
   bit         meas  = 0;

   led_matrix_bcm_driver #(
      .COLS      (COLS),
      .ROW_PAIRS (ROW_PAIRS),
      .DEPTH     (DEPTH),
      .CLK_DIV   (CLK_DIV),
      .BASE_T    (BASE_T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pix_addr   (pix_addr),
      .pix_top    (pix_top),
      .pix_bot    (pix_bot),
      .sclk       (sclk),
      .lat        (lat),
      .blank      (blank),
      .r1         (r1),
      .g1         (g1),
      .b1         (b1),
      .r2         (r2),
      .g2         (g2),
      .b2         (b2),
      .abc        (abc),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle   <= cycle + 1;
      pix_top <= fb_top[pix_addr];
      pix_bot <= fb_bot[pix_addr];
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cycle);
      end
   endfunction

   // Reference: a panel row for (row, plane) is the plane bit of each channel, column by column.
   task automatic push_plane(input int r, input int p);
      exp_t       e;
      logic [5:0] t, b;
      e.row   = r;
      e.plane = p;
      e.width = BASE_T * (2 ** p);
      e.data  = '0;
      for (int c = 0; c < COLS; c++) begin
         t = fb_top[r * COLS + c];
         b = fb_bot[r * COLS + c];
         e.data[6*c +: 6] = {t[2*DEPTH+p], t[DEPTH+p], t[p], b[2*DEPTH+p], b[DEPTH+p], b[p]};
      end
      q.push_back(e);
   endtask

   task automatic push_frames(input int frames, input int extra_planes);
      int n = 0;
      for (int f = 0; f < frames; f++)
         for (int r = 0; r < ROW_PAIRS; r++)
            for (int p = 0; p < DEPTH; p++)
               push_plane(r, p);
      for (int i = 0; i < extra_planes; i++) begin
         push_plane(n / DEPTH, n % DEPTH);
         n++;
      end
   endtask

   task automatic fill_fb(input bit const_top);
      for (int i = 0; i < NPIX; i++) begin
         fb_top[i] = const_top ? 6'b10_01_11 : 6'($urandom);
         fb_bot[i] = 6'($urandom);
      end
   endtask

   task automatic wait_frame_done(output int when);
      int t = 0;
      while (t < 2000) begin
         @(negedge clk);
         t++;
         if (frame_done) break;
      end
      check("frame_done_seen", frame_done, 1);
      when = cycle;
   endtask

   task automatic stop_mid_shift_and_drain();
      int t = 0;
      bit ok = 1;
      repeat ($urandom_range(0, 12)) @(negedge clk);
      #1 en = 1'b0;
      while ((q.size() != 0 || meas) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_queue_empty", q.size(), 0);
      repeat (30) begin
         @(negedge clk);
         ok &= (blank === 1'b1) && (sclk === 1'b0) && (lat === 1'b0);
      end
      check("idle_outputs", ok, 1);
   endtask

   // Panel-side monitor: shifts on sclk rises, pops one expectation per latch pulse.
   initial begin : monitor
      logic [5:0]       hold;
      logic [63:0]      act;
      int               k, width;
      bit               rst_d, sclk_d, lat_d, fd_d;
      logic [ABC_W-1:0] abc_d;
      exp_t             cur;
      k = 0; width = 0; act = '0; hold = '0;
      rst_d = 1; sclk_d = 0; lat_d = 0; fd_d = 0; abc_d = '0;
      forever begin
         @(negedge clk);
         if (rst || rst_d) begin
            meas = 0;
            k    = 0;
            act  = '0;
         end else begin
            if (sclk && !sclk_d) begin
               hold = {r1, g1, b1, r2, g2, b2};
               if (k < COLS) act[6*k +: 6] = hold;
               k++;
            end
            if (sclk && sclk_d) check("colour_hold_high", {r1, g1, b1, r2, g2, b2}, hold);
            if (sclk || lat) check("blank_outside_display", blank, 1);
            check("abc_changes_only_on_lat", (abc !== abc_d) && !lat, 0);
            check("lat_single_cycle", lat && lat_d, 0);
            check("frame_done_single_cycle", frame_done && fd_d, 0);
            if (meas) begin
               if (!blank) width++;
               else begin
                  check("display_width", width, cur.width);
                  meas = 0;
               end
            end
            if (lat) begin
               check("lat_expected", q.size() != 0, 1);
               if (q.size() != 0) begin
                  cur = q.pop_front();
                  check("latch_abc", abc, cur.row);
                  check("shift_count", k, COLS);
                  check("row_data", act, cur.data);
                  meas  = 1;
                  width = 0;
               end
               k   = 0;
               act = '0;
            end
         end
         rst_d  = rst;
         sclk_d = sclk;
         lat_d  = lat;
         fd_d   = frame_done;
         abc_d  = abc;
      end
   end

   initial begin : stimulus
      int t, fd1, fd2;

      // Constant top framebuffer, reset held with en=1.
      fill_fb(1);
      repeat (4) begin
         @(negedge clk);
         check("rst_blank", blank, 1);
         check("rst_sclk", sclk, 0);
         check("rst_lat", lat, 0);
         check("rst_abc", abc, 0);
         check("rst_pix_addr", pix_addr, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_colour", {r1, g1, b1, r2, g2, b2}, 0);
      end
      push_frames(2, 1);
      #1 rst = 1'b0;
      t = 0;
      while (t < 20) begin
         @(negedge clk);
         t++;
         if (sclk) break;
      end
      check("first_sclk_rise_cycles", t, 1 + CLK_DIV);
      wait_frame_done(fd1);
      wait_frame_done(fd2);
      check("frame_period", fd2 - fd1, FRAME_LEN);
      stop_mid_shift_and_drain();

      // Random framebuffers, restart from idle each time.
      for (int s = 0; s < 3; s++) begin
         fill_fb(0);
         push_frames(1, 1);
         #1 en = 1'b1;
         wait_frame_done(fd1);
         stop_mid_shift_and_drain();
      end

      // Reset pulsed while row 1 is on display.
      fill_fb(0);
      push_frames(1, 0);
      #1 en = 1'b1;
      t = 0;
      while (t < 1000) begin
         @(negedge clk);
         t++;
         if (lat && abc == 1'b1) break;
      end
      check("row1_lat_seen", lat && abc == 1'b1, 1);
      @(negedge clk);
      check("row1_displaying", blank, 0);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_blank", blank, 1);
      check("mid_rst_abc", abc, 0);
      check("mid_rst_lat", lat, 0);
      check("mid_rst_sclk", sclk, 0);
      #1;
      q.delete();
      push_frames(1, 1);
      rst = 1'b0;
      wait_frame_done(fd1);
      stop_mid_shift_and_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
